// File: rtl/hawk_bswap_pipe.sv
// Byte-reorder stage for AXI write payloads: per-beat lane/whole-word byte reversal
// (strobes follow data), valid/ready handshake, DEPTH-entry output FIFO, flush and beat counting.
module hawk_bswap_pipe #(
   parameter int DATA_W = 512,
   parameter int LANE_W = 64,
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [1:0]          in_mode_i,
   input  logic [ADDR_W-1:0]   in_addr_i,
   input  logic [DATA_W-1:0]   in_data_i,
   input  logic [DATA_W/8-1:0] in_strb_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [ADDR_W-1:0]   out_addr_o,
   output logic [DATA_W-1:0]   out_data_o,
   output logic [DATA_W/8-1:0] out_strb_o,
   output logic [CNT_W-1:0]    beat_cnt_o,
   output logic                mode_err_o,
   output logic                empty_o,
   output logic                full_o
);

   localparam int NB = DATA_W / 8;
   localparam int LB = LANE_W / 8;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_W-1:0] lane_data, word_data, sw_data;
   logic [NB-1:0]     lane_strb, word_strb, sw_strb;

   // Both permutations are involutions, so output byte gi is sourced from input byte p(gi).
   for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      localparam int LANE_SRC = (gi / LB) * LB + (LB - 1 - gi % LB);
      localparam int WORD_SRC = NB - 1 - gi;
      assign lane_data[gi*8 +: 8] = in_data_i[LANE_SRC*8 +: 8];
      assign word_data[gi*8 +: 8] = in_data_i[WORD_SRC*8 +: 8];
      assign lane_strb[gi]        = in_strb_i[LANE_SRC];
      assign word_strb[gi]        = in_strb_i[WORD_SRC];
   end

   always_comb begin
      sw_data = in_data_i;
      sw_strb = in_strb_i;
      case (in_mode_i)
         2'd1: begin
            sw_data = lane_data;
            sw_strb = lane_strb;
         end
         2'd2: begin
            sw_data = word_data;
            sw_strb = word_strb;
         end
         default: ;
      endcase
   end

   logic [ADDR_W-1:0] addr_mem_q [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [NB-1:0]     strb_mem_q [DEPTH];

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             mode_err_q, mode_err_d;
   logic             push, pop;

   assign full_o      = (count_q == DEPTH_C);
   assign empty_o     = (count_q == '0);
   assign out_valid_o = !empty_o;
   assign in_ready_o  = !full_o && !rst_i;
   assign beat_cnt_o  = beat_cnt_q;
   assign mode_err_o  = mode_err_q;

   // A flush swallows any transfer in the same cycle, on both sides.
   assign push = in_valid_i && in_ready_o && !flush_i;
   assign pop  = out_valid_o && out_ready_i && !flush_i;

   assign out_addr_o = empty_o ? '0 : addr_mem_q[rd_ptr_q];
   assign out_data_o = empty_o ? '0 : data_mem_q[rd_ptr_q];
   assign out_strb_o = empty_o ? '0 : strb_mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      beat_cnt_d = beat_cnt_q;
      mode_err_d = push && (in_mode_i == 2'd3);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         beat_cnt_q <= '0;
         mode_err_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         beat_cnt_q <= beat_cnt_d;
         mode_err_q <= mode_err_d;
      end
   end

   // Payload storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= in_addr_i;
         data_mem_q[wr_ptr_q] <= sw_data;
         strb_mem_q[wr_ptr_q] <= sw_strb;
      end
   end

endmodule

// File: tb/tb_hawk_bswap_pipe.sv
// Self-checking bench for hawk_bswap_pipe: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_hawk_bswap_pipe;

   localparam int DATA_W = 512;
   localparam int ADDR_W = 64;
   localparam int NB     = DATA_W / 8;
   localparam int L      = 8;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              flush_i = 1'b0;
   logic              in_valid_i = 1'b0;
   logic              in_ready_o;
   logic [1:0]        in_mode_i = 2'd0;
   logic [ADDR_W-1:0] in_addr_i = '0;
   logic [DATA_W-1:0] in_data_i = '0;
   logic [NB-1:0]     in_strb_i = '0;
   logic              out_valid_o;
   logic              out_ready_i = 1'b0;
   logic [ADDR_W-1:0] out_addr_o;
   logic [DATA_W-1:0] out_data_o;
   logic [NB-1:0]     out_strb_o;
   logic [31:0]       beat_cnt_o;
   logic              mode_err_o;
   logic              empty_o;
   logic              full_o;

   always #5 clk = ~clk;

   hawk_bswap_pipe dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_mode_i(in_mode_i),
      .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_strb_i(in_strb_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_strb_o(out_strb_o),
      .beat_cnt_o(beat_cnt_o), .mode_err_o(mode_err_o),
      .empty_o(empty_o), .full_o(full_o)
   );

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [NB-1:0]     strb;
   } beat_t;

   // Reference: apply the byte map p(b) literally, byte by byte.
   function automatic beat_t ref_beat(input logic [1:0] mode, input logic [ADDR_W-1:0] a,
                                      input logic [DATA_W-1:0] d, input logic [NB-1:0] s);
      beat_t r;
      int p;
      r.addr = a;
      r.data = '0;
      r.strb = '0;
      for (int b = 0; b < NB; b++) begin
         if (mode == 2'd1)      p = (b / L) * L + (L - 1 - b % L);
         else if (mode == 2'd2) p = NB - 1 - b;
         else                   p = b;
         r.data[p*8 +: 8] = d[b*8 +: 8];
         r.strb[p]        = s[b];
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   typedef struct {
      logic [1:0]  mode;
      logic [63:0] strb;
      logic [63:0] exp_strb;
      logic [7:0]  b0, b7, b8, b63;
   } vec_t;

   vec_t              vt [5];
   logic [DATA_W-1:0] pat;
   logic [ADDR_W-1:0] got [$];
   int                first_pop, last_pop;
   logic              c_acc;
   beat_t             mq [$];
   beat_t             hd;
   logic              exp_err;
   logic              acc, pp, fl;

   initial begin
      vt[0] = '{2'd1, 64'h1,    64'h80,                  8'h07, 8'h00, 8'h0F, 8'h38};
      vt[1] = '{2'd2, 64'h1,    64'h8000_0000_0000_0000, 8'h3F, 8'h38, 8'h37, 8'h00};
      vt[2] = '{2'd0, 64'hF0,   64'hF0,                  8'h00, 8'h07, 8'h08, 8'h3F};
      vt[3] = '{2'd3, 64'h3C,   64'h3C,                  8'h00, 8'h07, 8'h08, 8'h3F};
      vt[4] = '{2'd1, 64'h0100, 64'h8000,                8'h07, 8'h00, 8'h0F, 8'h38};
      for (int k = 0; k < NB; k++) pat[k*8 +: 8] = 8'(k);

      // Reset state
      #1;
      chk("rst_in_ready", 512'(in_ready_o), 512'(0));
      chk("rst_out_valid", 512'(out_valid_o), 512'(0));
      chk("rst_empty", 512'(empty_o), 512'(1));
      chk("rst_full", 512'(full_o), 512'(0));
      chk("rst_beat_cnt", 512'(beat_cnt_o), 512'(0));
      chk("rst_mode_err", 512'(mode_err_o), 512'(0));
      chk("rst_out_data", 512'(out_data_o), 512'(0));
      chk("rst_out_strb", 512'(out_strb_o), 512'(0));
      chk("rst_out_addr", 512'(out_addr_o), 512'(0));
      repeat (2) @(posedge clk);
      #3 rst_i = 1'b0;
      #1 chk("release_in_ready", 512'(in_ready_o), 512'(1));

      // Directed vector table
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid_i = 1'b1; in_mode_i = vt[i].mode; in_data_i = pat;
         in_strb_i = vt[i].strb; in_addr_i = 64'h2000 + 64'(i * 64); out_ready_i = 1'b1;
         @(posedge clk); #1;
         in_valid_i = 1'b0; exp_cnt++;
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 512'(out_valid_o), 512'(1));
         chk($sformatf("v%0d_b0", i), 512'(out_data_o[0 +: 8]), 512'(vt[i].b0));
         chk($sformatf("v%0d_b7", i), 512'(out_data_o[56 +: 8]), 512'(vt[i].b7));
         chk($sformatf("v%0d_b8", i), 512'(out_data_o[64 +: 8]), 512'(vt[i].b8));
         chk($sformatf("v%0d_b63", i), 512'(out_data_o[504 +: 8]), 512'(vt[i].b63));
         chk($sformatf("v%0d_strb", i), 512'(out_strb_o), 512'(vt[i].exp_strb));
         chk($sformatf("v%0d_cnt", i), 512'(beat_cnt_o), 512'(exp_cnt));
         chk($sformatf("v%0d_err", i), 512'(mode_err_o), 512'(vt[i].mode == 2'd3));
         if (vt[i].mode == 2'd3) begin
            @(negedge clk);
            chk("v3_err_drop", 512'(mode_err_o), 512'(0));
         end
      end

      // Mode 3 with all-0xA5 data passes unchanged
      @(posedge clk); #1;
      in_valid_i = 1'b1; in_mode_i = 2'd3; in_data_i = {64{8'hA5}}; in_strb_i = '1;
      @(posedge clk); #1;
      in_valid_i = 1'b0; exp_cnt++;
      @(negedge clk);
      chk("m3_data", out_data_o, {64{8'hA5}});
      chk("m3_err_hi", 512'(mode_err_o), 512'(1));
      chk("m3_cnt", 512'(beat_cnt_o), 512'(exp_cnt));
      @(negedge clk);
      chk("m3_err_lo", 512'(mode_err_o), 512'(0));

      // Backpressure: A and B fill the FIFO, C waits
      @(posedge clk); #1;
      out_ready_i = 1'b0; in_valid_i = 1'b1; in_mode_i = 2'd0; in_addr_i = 64'h1000;
      in_data_i = rand_data();
      @(posedge clk); #1; in_addr_i = 64'h1040; exp_cnt++;
      @(posedge clk); #1; in_addr_i = 64'h1080; exp_cnt++;
      @(negedge clk);
      chk("bp_full", 512'(full_o), 512'(1));
      chk("bp_in_ready", 512'(in_ready_o), 512'(0));
      chk("bp_head", 512'(out_addr_o), 512'(64'h1000));
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      got.delete(); first_pop = -1; last_pop = -1;
      for (int n = 0; n < 12 && got.size() < 3; n++) begin
         @(negedge clk);
         if (out_valid_o && out_ready_i) begin
            got.push_back(out_addr_o);
            if (first_pop < 0) first_pop = n;
            last_pop = n;
         end
         c_acc = in_valid_i && in_ready_o;
         @(posedge clk); #1;
         if (c_acc) begin
            in_valid_i = 1'b0; exp_cnt++;
         end
      end
      chk("bp_npop", 512'(got.size()), 512'(3));
      if (got.size() == 3) begin
         chk("bp_ord0", 512'(got[0]), 512'(64'h1000));
         chk("bp_ord1", 512'(got[1]), 512'(64'h1040));
         chk("bp_ord2", 512'(got[2]), 512'(64'h1080));
         chk("bp_rate", 512'(last_pop - first_pop), 512'(2));
      end
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_empty", 512'(empty_o), 512'(1));
      chk("bp_cnt", 512'(beat_cnt_o), 512'(exp_cnt));

      // Flush with two buffered beats and a pushed beat in the same cycle
      @(posedge clk); #1;
      out_ready_i = 1'b0; in_valid_i = 1'b1; in_addr_i = 64'h3000;
      @(posedge clk); #1; in_addr_i = 64'h3040; exp_cnt++;
      @(posedge clk); #1; in_addr_i = 64'h3080; exp_cnt++; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0; in_valid_i = 1'b0;
      @(negedge clk);
      chk("fl2_empty", 512'(empty_o), 512'(1));
      chk("fl2_valid", 512'(out_valid_o), 512'(0));
      chk("fl2_cnt", 512'(beat_cnt_o), 512'(exp_cnt));
      // Flush with room in the FIFO: the push is offered and must be dropped
      @(posedge clk); #1; in_valid_i = 1'b1; in_addr_i = 64'h3100; in_mode_i = 2'd3;
      @(posedge clk); #1; exp_cnt++; flush_i = 1'b1;
      @(negedge clk);
      chk("fl1_ready", 512'(in_ready_o), 512'(1));
      @(posedge clk); #1; flush_i = 1'b0; in_valid_i = 1'b0; in_mode_i = 2'd0;
      @(negedge clk);
      chk("fl1_empty", 512'(empty_o), 512'(1));
      chk("fl1_cnt", 512'(beat_cnt_o), 512'(exp_cnt));
      chk("fl1_err", 512'(mode_err_o), 512'(0));

      // Asynchronous reset with two beats buffered and count 5
      @(posedge clk); #3 rst_i = 1'b1;
      @(posedge clk); #3 rst_i = 1'b0;
      exp_cnt = 0;
      @(posedge clk); #1;
      out_ready_i = 1'b1; in_valid_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 in_valid_i = 1'b0;
      @(posedge clk); #1;
      out_ready_i = 1'b0; in_valid_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid_i = 1'b0;
      chk("ar_pre_cnt", 512'(beat_cnt_o), 512'(5));
      chk("ar_pre_full", 512'(full_o), 512'(1));
      #2 rst_i = 1'b1;
      #1;
      chk("ar_valid", 512'(out_valid_o), 512'(0));
      chk("ar_cnt", 512'(beat_cnt_o), 512'(0));
      chk("ar_ready", 512'(in_ready_o), 512'(0));
      chk("ar_empty", 512'(empty_o), 512'(1));
      @(posedge clk); #1;
      chk("ar_ready_hold", 512'(in_ready_o), 512'(0));
      #2 rst_i = 1'b0;
      #1 chk("ar_ready_rel", 512'(in_ready_o), 512'(1));
      chk("ar_valid_rel", 512'(out_valid_o), 512'(0));

      // Randomized run against the queue model
      exp_cnt = 0; exp_err = 1'b0; mq.delete();
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         in_valid_i  = ($urandom_range(0, 3) != 0);
         in_mode_i   = 2'($urandom_range(0, 3));
         in_addr_i   = {$urandom, $urandom};
         in_data_i   = rand_data();
         in_strb_i   = {$urandom, $urandom};
         out_ready_i = ($urandom_range(0, 2) != 0);
         flush_i     = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         chk("rnd_valid", 512'(out_valid_o), 512'(mq.size() != 0));
         chk("rnd_ready", 512'(in_ready_o), 512'(mq.size() < DEPTH));
         chk("rnd_cnt", 512'(beat_cnt_o), 512'(32'(exp_cnt)));
         chk("rnd_err", 512'(mode_err_o), 512'(exp_err));
         if (mq.size() != 0) begin
            hd = mq[0];
            chk("rnd_addr", 512'(out_addr_o), 512'(hd.addr));
            chk("rnd_data", out_data_o, hd.data);
            chk("rnd_strb", 512'(out_strb_o), 512'(hd.strb));
         end
         fl  = flush_i;
         acc = in_valid_i && (mq.size() < DEPTH) && !fl;
         pp  = out_ready_i && (mq.size() != 0) && !fl;
         exp_err = acc && (in_mode_i == 2'd3);
         if (fl) mq.delete();
         if (pp) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(ref_beat(in_mode_i, in_addr_i, in_data_i, in_strb_i));
            exp_cnt++;
         end
      end
      @(posedge clk); #1;
      in_valid_i = 1'b0; flush_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
